// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md_pkg
// Description : Shared encodings and helpers for the EXE multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

    // Operation select driven by the decoder.
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    // Control FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_t;

    // Bits needed to hold a count from 0 up to and including 'width'.
    function automatic int cntWidth(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/exe_muldiv_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : exe_muldiv_seq_if
// Description : Issue/result/HI-LO bundle between EXE control and the
//               multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface exe_muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             dz;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    // Pipeline control side.
    modport master (
        output start, op, a, b, flush, wr_hi, wr_lo, wdata,
        input  busy, done, dz, res_hi, res_lo, hi_q, lo_q
    );

    // Multiply/divide unit side.
    modport slave (
        input  start, op, a, b, flush, wr_hi, wr_lo, wdata,
        output busy, done, dz, res_hi, res_lo, hi_q, lo_q
    );
endinterface
`default_nettype wire

// File: rtl/md_div_core.sv
`default_nettype none
// ============================================================================
// Module      : md_div_core
// Description : Unsigned restoring radix-2 divider, one quotient bit per
//               cycle. fin is high during the final iteration cycle, so quo
//               and rem are valid from the following cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module md_div_core
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] dividend,
    input  wire logic [WIDTH-1:0] divisor,
    input  wire logic             kill,
    output logic      [WIDTH-1:0] quo,
    output logic      [WIDTH-1:0] rem,
    output logic                  fin
);
    localparam int CW = cntWidth(WIDTH);

    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_cnt;
    logic             r_active;

    // Partial remainder shifted left by one with the next dividend bit.
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_div};

    // Iterate: subtract when it does not go negative, else restore.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_quo    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (kill) begin
            r_active <= 1'b0;
        end else if (load) begin
            r_quo    <= dividend;
            r_rem    <= '0;
            r_div    <= divisor;
            r_cnt    <= CW'(WIDTH);
            r_active <= 1'b1;
        end else if (r_active) begin
            if (!w_diff[WIDTH]) begin
                r_rem <= w_diff[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], 1'b1};
            end else begin
                r_rem <= w_shift[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], 1'b0};
            end
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_active <= 1'b0;
            end
        end
    end

    assign fin = r_active && (r_cnt == CW'(1)) && !kill;
    assign quo = r_quo;
    assign rem = r_rem;

endmodule
`default_nettype wire

// File: rtl/exe_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : exe_muldiv_seq
// Description : Sequential multiply/divide unit owning architectural HI/LO.
//               Pipelined multiply, iterative signed/unsigned divide, flush
//               and mthi/mtlo support; result forwarded combinationally on done.
// Revision    : 1.0 - initial release
// ============================================================================
module exe_muldiv_seq
    import md_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 3
) (
    input wire logic         clk,
    input wire logic         rst,
    exe_muldiv_seq_if.slave  bus
);
    localparam int              MCW       = cntWidth(MUL_LAT);
    localparam logic [MCW-1:0]  c_mulLast = MCW'(MUL_LAT - 1);

    md_state_t          r_state;
    md_state_t          w_stateNext;
    logic [MCW-1:0]     r_mulCnt;
    logic [2*WIDTH-1:0] r_prodPipe [MUL_LAT];
    logic               r_negQ;
    logic               r_negR;
    logic               r_dz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_isDiv;
    logic               w_signedOp;
    logic               w_divZero;
    logic               w_aNeg;
    logic               w_bNeg;
    logic [WIDTH-1:0]   w_aMag;
    logic [WIDTH-1:0]   w_bMag;
    logic [2*WIDTH-1:0] w_aExt;
    logic [2*WIDTH-1:0] w_bExt;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic               w_divFin;
    logic [WIDTH-1:0]   w_fixHi;
    logic [WIDTH-1:0]   w_fixLo;
    logic               w_done;
    logic [WIDTH-1:0]   w_resHi;
    logic [WIDTH-1:0]   w_resLo;

    // Flush beats start; start is only taken from IDLE.
    assign w_accept   = bus.start && !bus.flush && (r_state == ST_IDLE);
    assign w_isDiv    = bus.op[1];
    assign w_signedOp = (bus.op == MD_MULT) || (bus.op == MD_DIV);
    assign w_divZero  = (bus.b == '0);

    // Full-width two's-complement product: extending both operands to 2W
    // makes the low 2W bits of the product correct for signed and unsigned.
    assign w_aExt = w_signedOp ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
    assign w_bExt = w_signedOp ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};
    assign w_prod = w_aExt * w_bExt;

    // Divider works on magnitudes; signs are reapplied in FIX.
    assign w_aNeg = w_signedOp && bus.a[WIDTH-1];
    assign w_bNeg = w_signedOp && bus.b[WIDTH-1];
    assign w_aMag = w_aNeg ? -bus.a : bus.a;
    assign w_bMag = w_bNeg ? -bus.b : bus.b;

    md_div_core #(.WIDTH(WIDTH)) u_divCore (
        .clk      (clk),
        .rst      (rst),
        .load     (w_accept && w_isDiv && !w_divZero),
        .dividend (w_aMag),
        .divisor  (w_bMag),
        .kill     (bus.flush),
        .quo      (w_quo),
        .rem      (w_rem),
        .fin      (w_divFin)
    );

    // Divide-by-zero reflects the current HI/LO so the commit is a no-op.
    // MIN / -1 wraps naturally: |MIN| / 1 negated is MIN again.
    assign w_fixLo = r_dz ? r_lo : (r_negQ ? -w_quo : w_quo);
    assign w_fixHi = r_dz ? r_hi : (r_negR ? -w_rem : w_rem);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state, done pulse and forwarded result.
    always_comb begin
        w_stateNext = r_state;
        w_done      = 1'b0;
        w_resHi     = '0;
        w_resLo     = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!w_isDiv)       w_stateNext = ST_MUL;
                    else if (w_divZero) w_stateNext = ST_FIX;
                    else                w_stateNext = ST_DIV;
                end
            end
            ST_MUL: begin
                if (r_mulCnt == c_mulLast) begin
                    w_stateNext = ST_IDLE;
                    w_done      = 1'b1;
                    w_resHi     = r_prodPipe[MUL_LAT-1][2*WIDTH-1:WIDTH];
                    w_resLo     = r_prodPipe[MUL_LAT-1][WIDTH-1:0];
                end
            end
            ST_DIV: begin
                if (w_divFin) w_stateNext = ST_FIX;
            end
            ST_FIX: begin
                w_stateNext = ST_IDLE;
                w_done      = 1'b1;
                w_resHi     = w_fixHi;
                w_resLo     = w_fixLo;
            end
            default: w_stateNext = ST_IDLE;
        endcase
        if (bus.flush) w_stateNext = ST_IDLE;
    end

    // Op context captured at issue, multiply counter and product pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mulCnt <= '0;
            r_negQ   <= 1'b0;
            r_negR   <= 1'b0;
            r_dz     <= 1'b0;
            for (int k = 0; k < MUL_LAT; k++) r_prodPipe[k] <= '0;
        end else begin
            if (w_accept) begin
                r_mulCnt      <= '0;
                r_negQ        <= w_aNeg ^ w_bNeg;
                r_negR        <= w_aNeg;
                r_dz          <= w_isDiv && w_divZero;
                r_prodPipe[0] <= w_prod;
            end else if (r_state == ST_MUL) begin
                r_mulCnt <= r_mulCnt + MCW'(1);
            end
            for (int k = 1; k < MUL_LAT; k++) r_prodPipe[k] <= r_prodPipe[k-1];
        end
    end

    // Architectural HI/LO: mthi/mtlo beat a same-cycle result per half.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (bus.wr_hi)   r_hi <= bus.wdata;
            else if (w_done) r_hi <= w_resHi;
            if (bus.wr_lo)   r_lo <= bus.wdata;
            else if (w_done) r_lo <= w_resLo;
        end
    end

    assign bus.busy   = (r_state != ST_IDLE);
    assign bus.done   = w_done;
    assign bus.dz     = w_done && r_dz;
    assign bus.res_hi = w_resHi;
    assign bus.res_lo = w_resLo;
    assign bus.hi_q   = r_hi;
    assign bus.lo_q   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_exe_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_exe_muldiv_seq
// Description : Directed self-checking bench for exe_muldiv_seq
//               (WIDTH=32, MUL_LAT=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exe_muldiv_seq;
    import md_pkg::*;

    logic clk = 1'b0;
    logic rst;

    exe_muldiv_seq_if #(.WIDTH(32)) bus ();

    exe_muldiv_seq #(.WIDTH(32), .MUL_LAT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int nCmp = 0;
    int nErr = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] preHi;
        logic [31:0] preLo;
        logic [31:0] expHi;
        logic [31:0] expLo;
        logic        expDz;
        int          expCyc;
    } vec_t;

    vec_t vecs [10];

    // One comparison.
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load HI then LO through the mthi/mtlo path.
    task automatic setHiLo(input logic [31:0] h, input logic [31:0] l);
        bus.wr_hi = 1'b1; bus.wdata = h;
        tick();
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b1; bus.wdata = l;
        tick();
        bus.wr_lo = 1'b0;
    endtask

    // Start an op in the current cycle (cycle 0) and wait for done with a
    // bounded budget; returns one cycle after done.
    task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag, output int cyc, output logic dz,
                         output logic [31:0] rh, output logic [31:0] rl);
        cyc = -1; dz = 1'b0; rh = '0; rl = '0;
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            chk($sformatf("%s_busy_c%0d", tag, k), {31'd0, bus.busy}, 32'd1);
            if (bus.done) begin
                cyc = k; dz = bus.dz; rh = bus.res_hi; rl = bus.res_lo;
                break;
            end
            tick();
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        logic        dz;
        logic [31:0] rh;
        logic [31:0] rl;
        logic        sawDone;

        //          op        a             b             preHi         preLo         expHi         expLo         dz    cyc
        vecs[0] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'hFFFFFFFE, 32'h00000001, 1'b0, 3};
        vecs[1] = '{MD_MULT,  32'hFFFFFFFD, 32'h00000007, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 3};
        vecs[2] = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
        vecs[3] = '{MD_DIVU,  32'h00000064, 32'h00000007, 32'h00000000, 32'h00000000, 32'h00000002, 32'h0000000E, 1'b0, 33};
        vecs[4] = '{MD_DIVU,  32'h00000064, 32'h00000000, 32'hAAAA0000, 32'h0000BBBB, 32'hAAAA0000, 32'h0000BBBB, 1'b1, 1};
        vecs[5] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h11111111, 32'h22222222, 32'h00000000, 32'h80000000, 1'b0, 33};
        vecs[6] = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000000, 32'h00000000, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33};
        vecs[7] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h00000000, 32'h00000000, 32'h40000000, 32'h00000000, 1'b0, 3};
        vecs[8] = '{MD_MULTU, 32'h80000000, 32'h00000002, 32'h00000000, 32'h00000000, 32'h00000001, 32'h00000000, 1'b0, 3};
        vecs[9] = '{MD_DIV,   32'h00000005, 32'h00000000, 32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222, 1'b1, 1};

        rst = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        bus.flush = 1'b0; bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wdata = '0;
        repeat (3) tick();

        chk("rst_busy",   {31'd0, bus.busy}, 32'd0);
        chk("rst_done",   {31'd0, bus.done}, 32'd0);
        chk("rst_dz",     {31'd0, bus.dz},   32'd0);
        chk("rst_res_hi", bus.res_hi, 32'd0);
        chk("rst_res_lo", bus.res_lo, 32'd0);
        chk("rst_hi_q",   bus.hi_q,   32'd0);
        chk("rst_lo_q",   bus.lo_q,   32'd0);
        rst = 1'b0;
        tick();

        // Table-driven vectors.
        for (int i = 0; i < 10; i++) begin
            setHiLo(vecs[i].preHi, vecs[i].preLo);
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("v%0d", i), cyc, dz, rh, rl);
            chk($sformatf("v%0d_done_cycle", i), cyc, vecs[i].expCyc);
            chk($sformatf("v%0d_dz", i), {31'd0, dz}, {31'd0, vecs[i].expDz});
            chk($sformatf("v%0d_res_hi", i), rh, vecs[i].expHi);
            chk($sformatf("v%0d_res_lo", i), rl, vecs[i].expLo);
            chk($sformatf("v%0d_hi_q", i), bus.hi_q, vecs[i].expHi);
            chk($sformatf("v%0d_lo_q", i), bus.lo_q, vecs[i].expLo);
            chk($sformatf("v%0d_busy_after", i), {31'd0, bus.busy}, 32'd0);
        end

        // Back-to-back: second start in the cycle right after done.
        runOp(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "b2b1", cyc, dz, rh, rl);
        chk("b2b1_done_cycle", cyc, 3);
        chk("b2b1_busy_after", {31'd0, bus.busy}, 32'd0);
        runOp(MD_MULT, 32'hFFFFFFFD, 32'h00000007, "b2b2", cyc, dz, rh, rl);
        chk("b2b2_done_cycle", cyc, 3);
        chk("b2b2_res_hi", rh, 32'hFFFFFFFF);
        chk("b2b2_res_lo", rl, 32'hFFFFFFEB);

        // Divide flushed in cycle 10; start in cycle 5 must be ignored.
        setHiLo(32'hCAFE0000, 32'h0000BEEF);
        sawDone = 1'b0;
        bus.start = 1'b1; bus.op = MD_DIV; bus.a = 32'd100; bus.b = 32'd3;
        for (int c = 1; c <= 50; c++) begin
            tick();
            if (c == 1) bus.start = 1'b0;
            if (bus.done) sawDone = 1'b1;
            if (c == 5) begin bus.start = 1'b1; bus.op = MD_MULTU; bus.a = 32'd2; bus.b = 32'd3; end
            if (c == 6) bus.start = 1'b0;
            if (c == 9) chk("flush_busy_c9", {31'd0, bus.busy}, 32'd1);
            if (c == 10) bus.flush = 1'b1;
            if (c == 11) begin
                bus.flush = 1'b0;
                chk("flush_busy_c11", {31'd0, bus.busy}, 32'd0);
            end
        end
        chk("flush_no_done", {31'd0, sawDone}, 32'd0);
        chk("flush_hi_q", bus.hi_q, 32'hCAFE0000);
        chk("flush_lo_q", bus.lo_q, 32'h0000BEEF);

        // Flush together with start in IDLE: start dropped.
        sawDone = 1'b0;
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = MD_MULTU; bus.a = 32'd5; bus.b = 32'd5;
        tick();
        bus.start = 1'b0; bus.flush = 1'b0;
        chk("flushstart_busy", {31'd0, bus.busy}, 32'd0);
        for (int c = 0; c < 6; c++) begin
            if (bus.done) sawDone = 1'b1;
            tick();
        end
        chk("flushstart_no_done", {31'd0, sawDone}, 32'd0);

        // mthi in the multu done cycle: HI takes the write, LO the result.
        setHiLo(32'd0, 32'd0);
        bus.start = 1'b1; bus.op = MD_MULTU; bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        chk("wrhi_done_c3", {31'd0, bus.done}, 32'd1);
        bus.wr_hi = 1'b1; bus.wdata = 32'h12345678;
        tick();
        bus.wr_hi = 1'b0;
        chk("wrhi_hi_q", bus.hi_q, 32'h12345678);
        chk("wrhi_lo_q", bus.lo_q, 32'h00000001);

        // Flush in the done cycle: result still commits.
        setHiLo(32'd0, 32'd0);
        bus.start = 1'b1; bus.op = MD_MULT; bus.a = 32'hFFFFFFFD; bus.b = 32'h00000007;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        chk("flushdone_done_c3", {31'd0, bus.done}, 32'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flushdone_hi_q", bus.hi_q, 32'hFFFFFFFF);
        chk("flushdone_lo_q", bus.lo_q, 32'hFFFFFFEB);

        // Reset in cycle 15 of a divide clears everything.
        setHiLo(32'h13572468, 32'h2468ACE0);
        bus.start = 1'b1; bus.op = MD_DIVU; bus.a = 32'd1000; bus.b = 32'd7;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c == 1) bus.start = 1'b0;
        end
        chk("midrst_busy_c15", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy",   {31'd0, bus.busy}, 32'd0);
        chk("midrst_done",   {31'd0, bus.done}, 32'd0);
        chk("midrst_dz",     {31'd0, bus.dz},   32'd0);
        chk("midrst_res_hi", bus.res_hi, 32'd0);
        chk("midrst_res_lo", bus.res_lo, 32'd0);
        chk("midrst_hi_q",   bus.hi_q,   32'd0);
        chk("midrst_lo_q",   bus.lo_q,   32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
`default_nettype wire
